// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encodings
// and the bundle of stall/flush controls produced each cycle.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MC_WAIT  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  typedef struct packed {
    logic mc_start;
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX observations in,
// stall/flush controls and multi-cycle handshake out.
interface pipe_hazard_ctrl_if;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_uses_rs2;
  logic [3:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_multicycle;
  logic       ex_branch_taken;
  logic       mc_done;
  logic       mc_start;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       mc_error;
  logic       busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
           ex_multicycle, ex_branch_taken, mc_done,
    input  mc_start, pc_stall, if_id_stall, id_ex_stall, if_id_flush,
           id_ex_flush, ex_mem_flush, mc_error, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
           ex_multicycle, ex_branch_taken, mc_done,
    output mc_start, pc_stall, if_id_stall, id_ex_stall, if_id_flush,
           id_ex_flush, ex_mem_flush, mc_error, busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the ID
// instruction. Kept standalone so the forwarding unit can reuse it.
module load_use_detect (
  input  logic       ex_mem_read,
  input  logic       id_valid,
  input  logic [3:0] ex_rd,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_uses_rs2,
  output logic       lu
);
  // r0 is hardwired to zero, so a load into it is never a real dependency
  assign lu = ex_mem_read & id_valid & (ex_rd != 4'd0) &
              ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX sequencing controller: load-use bubbles, taken-branch redirects and
// multi-cycle EX operations with a start/done/timeout handshake.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int MC_TIMEOUT      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  pif
);
  localparam logic [7:0] RDC = 8'(REDIRECT_CYCLES);
  localparam logic [7:0] TMO = 8'(MC_TIMEOUT);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       err, err_set, lu;
  ctrl_t      ctl;

  load_use_detect u_lu (
    .ex_mem_read (pif.ex_mem_read),
    .id_valid    (pif.id_valid),
    .ex_rd       (pif.ex_rd),
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_uses_rs2 (pif.id_uses_rs2),
    .lu          (lu)
  );

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      ST_RUN: begin
        if (pif.ex_branch_taken) begin
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
          if (RDC != 8'd0) begin
            state_nxt = ST_REDIRECT;
            cnt_nxt   = RDC;
          end
        end else if (pif.ex_multicycle) begin
          ctl.mc_start     = 1'b1;
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_flush = 1'b1;
          state_nxt        = ST_MC_WAIT;
          cnt_nxt          = 8'd1;
        end else if (lu) begin
          ctl.pc_stall    = 1'b1;
          ctl.if_id_stall = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        // done beats timeout so a result landing on the last cycle is kept
        if (pif.mc_done) begin
          state_nxt = ST_RUN;
          cnt_nxt   = 8'd0;
        end else if (cnt == TMO) begin
          err_set          = 1'b1;
          ctl.ex_mem_flush = 1'b1;
          state_nxt        = ST_RUN;
          cnt_nxt          = 8'd0;
        end else begin
          ctl.pc_stall     = 1'b1;
          ctl.if_id_stall  = 1'b1;
          ctl.id_ex_stall  = 1'b1;
          ctl.ex_mem_flush = 1'b1;
          cnt_nxt          = cnt + 8'd1;
        end
      end
      ST_REDIRECT: begin
        ctl.if_id_flush = 1'b1;
        cnt_nxt         = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= 8'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err | err_set;
    end
  end

  // everything is held quiet while reset is asserted
  assign pif.mc_start     = rst_n & ctl.mc_start;
  assign pif.pc_stall     = rst_n & ctl.pc_stall;
  assign pif.if_id_stall  = rst_n & ctl.if_id_stall;
  assign pif.id_ex_stall  = rst_n & ctl.id_ex_stall;
  assign pif.if_id_flush  = rst_n & ctl.if_id_flush;
  assign pif.id_ex_flush  = rst_n & ctl.id_ex_flush;
  assign pif.ex_mem_flush = rst_n & ctl.ex_mem_flush;
  assign pif.mc_error     = rst_n & err;
  assign pif.busy         = rst_n & (state != ST_RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, a hand-written timeout
// sequence, and random traffic against a behavioural model on two configs.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       uses;
    logic [3:0] rd;
    logic       mr;
    logic       mc;
    logic       br;
    logic       done;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [8:0] exp;
  } row_t;

  // output vector layout
  localparam logic [8:0] B_MCS  = 9'h100;
  localparam logic [8:0] B_PCS  = 9'h080;
  localparam logic [8:0] B_IFS  = 9'h040;
  localparam logic [8:0] B_IDS  = 9'h020;
  localparam logic [8:0] B_IFF  = 9'h010;
  localparam logic [8:0] B_IDF  = 9'h008;
  localparam logic [8:0] B_EMF  = 9'h004;
  localparam logic [8:0] B_ERR  = 9'h002;
  localparam logic [8:0] B_BUSY = 9'h001;
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_LU   = B_PCS | B_IFS | B_IDF;
  localparam logic [8:0] O_MCS  = B_MCS | B_PCS | B_IFS | B_IDS | B_EMF;
  localparam logic [8:0] O_MCW  = B_PCS | B_IFS | B_IDS | B_EMF | B_BUSY;
  localparam logic [8:0] O_BR   = B_IFF | B_IDF;
  localparam logic [8:0] O_RD   = B_IFF | B_BUSY;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if ifb ();

  pipe_hazard_ctrl #(.REDIRECT_CYCLES(2), .MC_TIMEOUT(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .pif(ifa));
  pipe_hazard_ctrl #(.REDIRECT_CYCLES(0), .MC_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .pif(ifb));

  logic [8:0] oa, ob;
  assign oa = {ifa.mc_start, ifa.pc_stall, ifa.if_id_stall, ifa.id_ex_stall,
               ifa.if_id_flush, ifa.id_ex_flush, ifa.ex_mem_flush,
               ifa.mc_error, ifa.busy};
  assign ob = {ifb.mc_start, ifb.pc_stall, ifb.if_id_stall, ifb.id_ex_stall,
               ifb.if_id_flush, ifb.id_ex_flush, ifb.ex_mem_flush,
               ifb.mc_error, ifb.busy};

  int errors = 0;
  int checks = 0;

  // Reference model: an operation in flight with elapsed cycle count, a count
  // of remaining redirect flush cycles, and a sticky error flag.
  int P_R[2]  = '{2, 0};
  int P_TO[2] = '{5, 4};
  bit m_mc[2]  = '{0, 0};
  int m_el[2]  = '{0, 0};
  int m_rd[2]  = '{0, 0};
  bit m_err[2] = '{0, 0};

  function automatic bit model_lu(in_t v);
    return v.mr && v.valid && v.rd != 0 &&
           (v.rd == v.rs1 || (v.uses && v.rd == v.rs2));
  endfunction

  function automatic logic [8:0] model_out(int k, in_t v);
    logic [8:0] o = '0;
    if (!v.rst_n) return '0;
    if (m_err[k]) o |= B_ERR;
    if (m_mc[k]) begin
      o |= B_BUSY;
      if (v.done) ;
      else if (m_el[k] == P_TO[k]) o |= B_EMF;
      else o |= B_PCS | B_IFS | B_IDS | B_EMF;
    end else if (m_rd[k] > 0) begin
      o |= B_IFF | B_BUSY;
    end else if (v.br) o |= B_IFF | B_IDF;
    else if (v.mc) o |= B_MCS | B_PCS | B_IFS | B_IDS | B_EMF;
    else if (model_lu(v)) o |= B_PCS | B_IFS | B_IDF;
    return o;
  endfunction

  task automatic model_step(int k, in_t v);
    if (!v.rst_n) begin
      m_mc[k] = 0; m_el[k] = 0; m_rd[k] = 0; m_err[k] = 0;
    end else if (m_mc[k]) begin
      if (v.done) m_mc[k] = 0;
      else if (m_el[k] == P_TO[k]) begin m_mc[k] = 0; m_err[k] = 1; end
      else m_el[k]++;
    end else if (m_rd[k] > 0) m_rd[k]--;
    else if (v.br) m_rd[k] = P_R[k];
    else if (v.mc) begin m_mc[k] = 1; m_el[k] = 1; end
  endtask

  task automatic drive(in_t v);
    rst_n = v.rst_n;
    ifa.id_valid = v.valid;  ifb.id_valid = v.valid;
    ifa.id_rs1 = v.rs1;      ifb.id_rs1 = v.rs1;
    ifa.id_rs2 = v.rs2;      ifb.id_rs2 = v.rs2;
    ifa.id_uses_rs2 = v.uses; ifb.id_uses_rs2 = v.uses;
    ifa.ex_rd = v.rd;        ifb.ex_rd = v.rd;
    ifa.ex_mem_read = v.mr;  ifb.ex_mem_read = v.mr;
    ifa.ex_multicycle = v.mc; ifb.ex_multicycle = v.mc;
    ifa.ex_branch_taken = v.br; ifb.ex_branch_taken = v.br;
    ifa.mc_done = v.done;    ifb.mc_done = v.done;
  endtask

  task automatic cmp(string name, int idx, logic [8:0] got, logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic apply(int idx, in_t v, bit chka, logic [8:0] ea,
                       bit chkb, logic [8:0] eb);
    drive(v);
    @(negedge clk);
    cmp("model_a", idx, oa, model_out(0, v));
    cmp("model_b", idx, ob, model_out(1, v));
    if (chka) cmp("vec_a", idx, oa, ea);
    if (chkb) cmp("vec_b", idx, ob, eb);
    @(posedge clk);
    model_step(0, v);
    model_step(1, v);
    #1;
  endtask

  function automatic in_t mk(bit rst, bit valid, int rs1, int rs2, bit uses,
                             int rd, bit mr, bit mc, bit br, bit done);
    in_t v;
    v.rst_n = rst; v.valid = valid; v.rs1 = 4'(rs1); v.rs2 = 4'(rs2);
    v.uses = uses; v.rd = 4'(rd); v.mr = mr; v.mc = mc; v.br = br;
    v.done = done;
    return v;
  endfunction

  row_t tbl[$];

  task automatic add(in_t v, logic [8:0] e);
    row_t r;
    r.in = v; r.exp = e;
    tbl.push_back(r);
  endtask

  initial begin
    in_t idle, lu3, mc1, alle, rnd;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu3  = mk(1, 1, 3, 1, 0, 3, 1, 0, 0, 0);
    mc1  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    alle = mk(1, 1, 3, 0, 0, 3, 1, 1, 1, 0);

    add(mk(0, 1, 3, 0, 0, 3, 1, 1, 0, 0), O_NONE);
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_NONE);
    add(idle, O_NONE);
    add(lu3, O_LU);
    add(mk(1, 1, 3, 1, 0, 3, 0, 0, 0, 0), O_NONE);
    add(mk(1, 1, 1, 5, 1, 5, 1, 0, 0, 0), O_LU);
    add(mk(1, 1, 1, 5, 0, 5, 1, 0, 0, 0), O_NONE);
    add(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0), O_NONE);
    add(mk(1, 0, 3, 0, 0, 3, 1, 0, 0, 0), O_NONE);
    add(alle, O_BR);
    add(alle, O_RD);
    add(alle, O_RD);
    add(idle, O_NONE);
    add(mc1, O_MCS);
    add(mc1, O_MCW);
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_MCW);
    add(mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0), O_MCW);
    add(mc1, O_MCW);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), B_BUSY);
    add(idle, O_NONE);
    add(mc1, O_MCS);
    for (int i = 0; i < 4; i++) add(mc1, O_MCW);
    add(mc1, B_EMF | B_BUSY);
    add(idle, B_ERR);
    add(lu3, O_LU | B_ERR);
    add(mc1, O_MCS | B_ERR);
    add(mc1, O_MCW | B_ERR);
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_NONE);
    add(idle, O_NONE);
    add(lu3, O_LU);
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_MCS);
    add(mc1, O_MCW);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), B_BUSY);
    add(idle, O_NONE);

    foreach (tbl[i]) apply(i, tbl[i].in, 1'b1, tbl[i].exp, 1'b0, '0);

    // timeout and zero-length redirect on the second configuration
    apply(100, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, '0, 1'b1, O_NONE);
    apply(101, mc1, 1'b0, '0, 1'b1, O_MCS);
    for (int i = 0; i < 3; i++) apply(102 + i, mc1, 1'b0, '0, 1'b1, O_MCW);
    apply(105, mc1, 1'b0, '0, 1'b1, B_EMF | B_BUSY);
    apply(106, idle, 1'b0, '0, 1'b1, B_ERR);
    apply(107, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, '0, 1'b1, O_BR | B_ERR);
    apply(108, idle, 1'b0, '0, 1'b1, B_ERR);
    apply(109, lu3, 1'b0, '0, 1'b1, O_LU | B_ERR);

    for (int i = 0; i < 600; i++) begin
      rnd.rst_n = ($urandom_range(0, 49) != 0);
      rnd.valid = ($urandom_range(0, 3) != 0);
      rnd.rs1   = 4'($urandom_range(0, 3));
      rnd.rs2   = 4'($urandom_range(0, 3));
      rnd.uses  = 1'($urandom);
      rnd.rd    = 4'($urandom_range(0, 3));
      rnd.mr    = 1'($urandom);
      rnd.mc    = ($urandom_range(0, 5) == 0);
      rnd.br    = ($urandom_range(0, 7) == 0);
      rnd.done  = ($urandom_range(0, 4) == 0);
      apply(200 + i, rnd, 1'b0, '0, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
